// File: rtl/wait_state_ram_if.sv
// Processor memory bus between a bus master and wait_state_ram.
// The master holds enable high until it sees MFC.
interface wait_state_ram_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] MAR;
  logic [DATA_W-1:0] bus;
  logic              rnw;
  logic              enable;
  logic [DATA_W-1:0] MBR;
  logic              MFC;
  logic              BUSY;
  logic              ERR;

  modport master (output MAR, bus, rnw, enable, input MBR, MFC, BUSY, ERR);
  modport slave  (input MAR, bus, rnw, enable, output MBR, MFC, BUSY, ERR);
endinterface

// File: rtl/wait_state_ram.sv
// Synchronous RAM with an enable/MFC handshake and WAIT_CYC wait states.
// Requests are latched in IDLE; out-of-range addresses report ERR and leave memory and MBR untouched.
module wait_state_ram #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 8,
  parameter int DEPTH    = 256,
  parameter int WAIT_CYC = 2
) (
  input  logic            CLK,
  input  logic            RST,
  wait_state_ram_if.slave mem_bus
);

  localparam int CNT_W = (WAIT_CYC < 1) ? 1 : $clog2(WAIT_CYC + 1);
  localparam int IDX_W = (DEPTH < 2) ? 1 : $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              rnw_q;
  logic [DATA_W-1:0] mbr_q;
  logic              mfc_q;
  logic              busy_q;
  logic              err_q;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_data;
  logic              acc_rnw;
  logic              acc_fire;
  logic              acc_hit;
  logic [IDX_W-1:0]  acc_idx;

  // With no wait states the access happens on the sampling edge, so it uses the live bus.
  // NOTE: every signal gets a default before the case, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    acc_addr = addr_q;
    acc_data = data_q;
    acc_rnw  = rnw_q;
    acc_fire = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (WAIT_CYC == 0) begin
          acc_addr = mem_bus.MAR;
          acc_data = mem_bus.bus;
          acc_rnw  = mem_bus.rnw;
          acc_fire = mem_bus.enable;
        end
      end
      S_WAIT:  acc_fire = (cnt == CNT_W'(1));
      default: acc_fire = 1'b0;
    endcase
    if (RST) acc_fire = 1'b0;
  end

  assign acc_hit = ({1'b0, acc_addr} < (ADDR_W + 1)'(DEPTH));
  assign acc_idx = acc_addr[IDX_W-1:0];

  // NOTE: the storage array has no reset; its contents survive RST, and this keeps it mappable to RAM.
  always_ff @(posedge CLK) begin
    if (acc_fire && acc_hit && !acc_rnw) mem[acc_idx] <= acc_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= S_IDLE;
      cnt    <= '0;
      addr_q <= '0;
      data_q <= '0;
      rnw_q  <= 1'b0;
      mbr_q  <= '0;
      mfc_q  <= 1'b0;
      busy_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      if (acc_fire && acc_hit && acc_rnw) mbr_q <= mem[acc_idx];
      unique case (state)
        S_IDLE: begin
          if (mem_bus.enable) begin
            addr_q <= mem_bus.MAR;
            data_q <= mem_bus.bus;
            rnw_q  <= mem_bus.rnw;
            cnt    <= CNT_W'(WAIT_CYC);
            if (WAIT_CYC == 0) begin
              state <= S_ACK;
              mfc_q <= 1'b1;
              err_q <= !acc_hit;
            end else begin
              state  <= S_WAIT;
              busy_q <= 1'b1;
            end
          end
        end
        S_WAIT: begin
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            busy_q <= 1'b0;
            // An abandoned request still commits its access but is never acknowledged.
            if (mem_bus.enable) begin
              state <= S_ACK;
              mfc_q <= 1'b1;
              err_q <= !acc_hit;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        S_ACK: begin
          if (!mem_bus.enable) begin
            state <= S_IDLE;
            mfc_q <= 1'b0;
            err_q <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign mem_bus.MBR  = mbr_q;
  assign mem_bus.MFC  = mfc_q;
  assign mem_bus.BUSY = busy_q;
  assign mem_bus.ERR  = err_q;

endmodule
